window_mac3: RTL
================

WINDOW_MAC3 -- requirements
Module: window_mac3

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 8: width of one activation and one weight.
REQ-002 SHALL have parameter NUM_RDATA, default 3: window size; fixed at 3 in this revision.
REQ-003 SHALL have parameter ACC_WIDTH, default 20: signed accumulator and result width.
REQ-004 SHALL have parameter CNT_WIDTH, default 4: width of the group-length input.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wgt_wr, input, 1 bit: weight load strobe.
REQ-008 SHALL have port wgt_data, input, DAT_WIDTH*3 bits: signed weights, w0 in [7:0], w1 in [15:8], w2 in [23:16].
REQ-009 SHALL have port num_acc, input, CNT_WIDTH bits: number of windows per accumulation group.
REQ-010 SHALL have port in_data, input, DAT_WIDTH*3 bits: unsigned window from the upstream pop-1-out-3 FIFO, a0 in [7:0], a1 in [15:8], a2 in [23:16].
REQ-011 SHALL have port in_data_val, input, 1 bit: in_data is valid this cycle.
REQ-012 SHALL have port out_data, output, ACC_WIDTH bits: signed group result.
REQ-013 SHALL have port out_data_val, output, 1 bit: one-cycle pulse marking a new out_data.
REQ-014 SHALL have port busy, output, 1 bit: a group is open or any pipeline stage holds valid data.
REQ-015 SHALL have port wgt_loaded, output, 1 bit: weights are loaded and the block is in state READY.
REQ-016 SHALL have port sat, output, 1 bit: sticky flag; some result saturated since the last weight load.
REQ-017 SHALL have port wgt_err, output, 1 bit: sticky flag; wgt_wr arrived while busy.

Function
REQ-018 SHALL implement a two-state FSM: IDLE (no weights loaded) and READY. IDLE goes to READY on wgt_wr. READY stays in READY.
REQ-019 SHALL, when wgt_wr=1 and busy=0, capture wgt_data into the weight registers, clear sat, and assert wgt_loaded from the next cycle.
REQ-020 SHALL, when wgt_wr=1 and busy=1, ignore the write, keep the old weights, and set wgt_err; wgt_err clears only on reset.
REQ-021 SHALL, in IDLE, ignore in_data_val; no pipeline activity and no counter change.
REQ-022 SHALL, in READY, accept every cycle with in_data_val=1; there is no backpressure and gaps between valids are allowed.
REQ-023 SHALL sample num_acc on the first accepted window of a group; num_acc=0 is treated as 1.
REQ-024 SHALL keep a window counter and tag each accepted window with first/last flags; the counter returns to 0 after the last window of a group.
REQ-025 SHALL run pipeline stage 1: register three signed products ai*wi, each 2*DAT_WIDTH+1 bits, activation zero-extended.
REQ-026 SHALL run pipeline stage 2: register the sign-extended sum of the three products.
REQ-027 SHALL run pipeline stage 3: if first, acc = sum; otherwise acc = acc + sum, saturated to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-028 SHALL, on any saturation, clamp the accumulator and set sat.
REQ-029 SHALL, when stage 3 processes a last window, update out_data to the final acc and pulse out_data_val in that same cycle; the pulse occurs 3 cycles after the in_data_val of the last window.
REQ-030 SHALL hold out_data between pulses.
REQ-031 SHALL allow back-to-back groups; the first window of the next group may arrive in the cycle after the last window of the previous group.
REQ-032 SHALL leave num_acc changes mid-group without effect until the next group.

Reset
REQ-033 SHALL, while rst=1, immediately force: FSM=IDLE; weights, counter, pipeline valids, and accumulator to 0; out_data=0, out_data_val=0, busy=0, wgt_loaded=0, sat=0, wgt_err=0.
REQ-034 SHALL discard a partial group on reset mid-operation; no out_data_val follows the reset.

Verification
REQ-035 SHALL cover: weights w0=1, w1=2, w2=3; num_acc=1; window (10,20,30) at cycle t -> out_data=140, out_data_val=1 at t+3 only.
REQ-036 SHALL cover: weights all 1; num_acc=3; windows (1,1,1), (2,2,2), (3,3,3) back-to-back -> single pulse out_data=18, 3 cycles after the third window.
REQ-037 SHALL cover: weights all 127, data 255, num_acc=6 -> out_data=524287, sat=1; then weights all -128 -> out_data=-524288, sat=1.
REQ-038 SHALL cover: wgt_wr of new weights mid-group -> wgt_err=1 and the group result uses the old weights.
REQ-039 SHALL cover: in_data_val pulses before any wgt_wr -> out_data_val stays 0, busy stays 0, wgt_loaded=0.
REQ-040 SHALL cover: rst asserted after 2 of 3 windows, then weights reloaded, then 3 new windows -> exactly one pulse, with a result built only from the new windows.

Source files
------------

// File: rtl/window_mac3.sv
// ============================================================================
// Module  : window_mac3
// Purpose : 3-tap windowed multiply-accumulate. Produces one saturated signed
//           result for each group of windows.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module window_mac3 #(
   parameter int DAT_WIDTH = 8,
   parameter int NUM_RDATA = 3,
   parameter int ACC_WIDTH = 20,
   parameter int CNT_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wgt_wr,
   input  logic [DAT_WIDTH*NUM_RDATA-1:0]    wgt_data,
   input  logic [CNT_WIDTH-1:0]              num_acc,
   input  logic [DAT_WIDTH*NUM_RDATA-1:0]    in_data,
   input  logic                              in_data_val,
   output logic signed [ACC_WIDTH-1:0]       out_data,
   output logic                              out_data_val,
   output logic                              busy,
   output logic                              wgt_loaded,
   output logic                              sat,
   output logic                              wgt_err
);

   localparam int PROD_W = 2*DAT_WIDTH + 1;
   localparam int SUM_W  = PROD_W + $clog2(NUM_RDATA);
   localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [EXT_W-1:0]     ACC_MAX_X = {{(EXT_W-ACC_WIDTH){1'b0}}, ACC_MAX};
   localparam logic [EXT_W-1:0]     ACC_MIN_X = {{(EXT_W-ACC_WIDTH){1'b1}}, ACC_MIN};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                                state_q, state_d;
   logic [DAT_WIDTH*NUM_RDATA-1:0]        wgt_q, wgt_d;
   logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]                  len_q, len_d;
   logic                                  s1_vld_q, s1_vld_d;
   logic                                  s1_first_q, s1_first_d;
   logic                                  s1_last_q, s1_last_d;
   logic [NUM_RDATA-1:0][PROD_W-1:0]      prod_q, prod_d;
   logic                                  s2_vld_q, s2_vld_d;
   logic                                  s2_first_q, s2_first_d;
   logic                                  s2_last_q, s2_last_d;
   logic [SUM_W-1:0]                      sum_q, sum_d;
   logic [ACC_WIDTH-1:0]                  acc_q, acc_d;
   logic [ACC_WIDTH-1:0]                  out_q, out_d;
   logic                                  out_val_q, out_val_d;
   logic                                  sat_q, sat_d;
   logic                                  err_q, err_d;

   logic                                  busy_w;
   logic                                  accept_w;
   logic                                  first_w;
   logic                                  last_w;
   logic [CNT_WIDTH-1:0]                  len_eff_w;
   logic [CNT_WIDTH-1:0]                  len_use_w;
   logic [CNT_WIDTH-1:0]                  cnt_inc_w;
   logic [NUM_RDATA-1:0][PROD_W-1:0]      act_x_w;
   logic [NUM_RDATA-1:0][PROD_W-1:0]      wgt_x_w;
   logic [EXT_W-1:0]                      sum_x_w;
   logic [EXT_W-1:0]                      acc_x_w;
   logic [EXT_W-1:0]                      tot_x_w;

   always_comb begin
      state_d    = state_q;
      wgt_d      = wgt_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      s1_vld_d   = 1'b0;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      prod_d     = prod_q;
      s2_vld_d   = 1'b0;
      s2_first_d = s2_first_q;
      s2_last_d  = s2_last_q;
      sum_d      = sum_q;
      acc_d      = acc_q;
      out_d      = out_q;
      out_val_d  = 1'b0;
      sat_d      = sat_q;
      err_d      = err_q;
      act_x_w    = '0;
      wgt_x_w    = '0;
      sum_x_w    = '0;
      acc_x_w    = '0;
      tot_x_w    = '0;

      busy_w    = (cnt_q != '0) | s1_vld_q | s2_vld_q;
      accept_w  = (state_q == ST_READY) && in_data_val;
      first_w   = (cnt_q == '0);
      len_eff_w = (num_acc == '0) ? CNT_ONE : num_acc;
      len_use_w = first_w ? len_eff_w : len_q;
      cnt_inc_w = cnt_q + CNT_ONE;
      last_w    = (cnt_inc_w == len_use_w);

      // A weight write while work is in flight would corrupt the open group.
      if (wgt_wr) begin
         if (busy_w) begin
            err_d = 1'b1;
         end else begin
            wgt_d   = wgt_data;
            sat_d   = 1'b0;
            state_d = ST_READY;
         end
      end

      // Stage 1: products with activation zero-extended, weight sign-extended.
      for (int i = 0; i < NUM_RDATA; i++) begin
         act_x_w[i] = {{(DAT_WIDTH+1){1'b0}}, in_data[i*DAT_WIDTH +: DAT_WIDTH]};
         wgt_x_w[i] = {{(DAT_WIDTH+1){wgt_q[i*DAT_WIDTH+DAT_WIDTH-1]}},
                       wgt_q[i*DAT_WIDTH +: DAT_WIDTH]};
      end
      if (accept_w) begin
         s1_vld_d   = 1'b1;
         s1_first_d = first_w;
         s1_last_d  = last_w;
         cnt_d      = last_w ? '0 : cnt_inc_w;
         if (first_w) begin
            len_d = len_eff_w;
         end
         for (int i = 0; i < NUM_RDATA; i++) begin
            prod_d[i] = act_x_w[i] * wgt_x_w[i];
         end
      end

      // Stage 2: sign-extended sum of the products.
      if (s1_vld_q) begin
         s2_vld_d   = 1'b1;
         s2_first_d = s1_first_q;
         s2_last_d  = s1_last_q;
         sum_d      = '0;
         for (int i = 0; i < NUM_RDATA; i++) begin
            sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
         end
      end

      // Stage 3: accumulate in a widened domain, then clamp to ACC_WIDTH.
      if (s2_vld_q) begin
         sum_x_w = {{(EXT_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
         acc_x_w = {{(EXT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
         tot_x_w = s2_first_q ? sum_x_w : (acc_x_w + sum_x_w);
         if ($signed(tot_x_w) > $signed(ACC_MAX_X)) begin
            acc_d = ACC_MAX;
            sat_d = 1'b1;
         end else if ($signed(tot_x_w) < $signed(ACC_MIN_X)) begin
            acc_d = ACC_MIN;
            sat_d = 1'b1;
         end else begin
            acc_d = tot_x_w[ACC_WIDTH-1:0];
         end
         if (s2_last_q) begin
            out_d     = acc_d;
            out_val_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wgt_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         prod_q     <= '0;
         s2_vld_q   <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         sum_q      <= '0;
         acc_q      <= '0;
         out_q      <= '0;
         out_val_q  <= 1'b0;
         sat_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wgt_q      <= wgt_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         s1_vld_q   <= s1_vld_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         prod_q     <= prod_d;
         s2_vld_q   <= s2_vld_d;
         s2_first_q <= s2_first_d;
         s2_last_q  <= s2_last_d;
         sum_q      <= sum_d;
         acc_q      <= acc_d;
         out_q      <= out_d;
         out_val_q  <= out_val_d;
         sat_q      <= sat_d;
         err_q      <= err_d;
      end
   end

   assign out_data     = out_q;
   assign out_data_val = out_val_q;
   assign busy         = busy_w;
   assign wgt_loaded   = (state_q == ST_READY);
   assign sat          = sat_q;
   assign wgt_err      = err_q;

endmodule

`default_nettype wire
